apb_master_module: RTL and testbench
====================================

Name: apb_master_module

Overview:
- APB initiator that converts a simple command/response handshake into APB4 transfers toward the matmul accelerator's APB slave port.
- Used by the block-level bench and by the future system-side host to load operands, set control, poll flags and read results.
- Honours accelerator busy: write commands are held off while busy_i is high; reads always proceed.
- Bounds every transfer with a wait-state timeout.

Parameters:
DATA_WIDTH, 8, element width in bits
BUS_WIDTH, 16, APB data width
ADDR_WIDTH, 32, APB address width
TIMEOUT_CYCLES, 16, max ACCESS-phase cycles before abort (>=2)
MAX_DIM (localparam), BUS_WIDTH/DATA_WIDTH, strobe width

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  asynchronous active-low reset
cmd_valid_i  in  1  command request
cmd_ready_o  out  1  command accepted when high with cmd_valid_i
cmd_write_i  in  1  1=write, 0=read
cmd_addr_i  in  ADDR_WIDTH  target address
cmd_wdata_i  in  BUS_WIDTH  write data
cmd_strb_i  in  MAX_DIM  write byte strobes
rsp_valid_o  out  1  one-cycle response pulse
rsp_rdata_o  out  BUS_WIDTH  read data (0 for writes/errors)
rsp_err_o  out  1  pslverr or timeout
psel_o  out  1  APB select
penable_o  out  1  APB enable
pwrite_o  out  1  APB direction
pstrb_o  out  MAX_DIM  APB strobes
pwdata_o  out  BUS_WIDTH  APB write data
paddr_o  out  ADDR_WIDTH  APB address
pready_i  in  1  slave ready
pslverr_i  in  1  slave error
prdata_i  in  BUS_WIDTH  slave read data
busy_i  in  1  accelerator busy (from slave busy_o)

Behaviour:
- Reset (async, rst_ni=0): state IDLE; all outputs 0, except cmd_ready_o, which follows the IDLE rule below once reset deasserts. Timeout counter 0. An in-flight transfer is dropped with no response.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready_o = ~(cmd_write_i & busy_i). This is combinational on inputs; a read is never blocked.
  - On cmd_valid_i & cmd_ready_o at a clock edge: register write, addr, wdata, strb; go to SETUP.
  - Reads register pwdata=0 and pstrb=0 (APB4 rule).
- SETUP (exactly 1 cycle): psel_o=1, penable_o=0, paddr/pwrite/pwdata/pstrb driven from the registered command. Go to ACCESS.
- ACCESS: psel_o=1, penable_o=1; address/data stable.
  - pready_i=1: capture rdata = read ? prdata_i : 0, and err = pslverr_i; go to RESP.
  - pready_i=0: counter increments. When counter = TIMEOUT_CYCLES-1 and pready_i is still 0, go to RESP with err=1 and rdata=0.
  - Counter clears on leaving ACCESS.
- RESP (1 cycle): psel_o=0, penable_o=0, rsp_valid_o=1 with captured rsp_rdata_o/rsp_err_o; go to IDLE. No response backpressure.
- Outside RESP: rsp_valid_o=0; rsp_rdata_o/rsp_err_o hold their last value.
- Latency: accept edge T, SETUP T+1, ACCESS T+2, response at T+3 with zero wait states; +1 cycle per wait state.
- Throughput: at most one transfer per 4 cycles; no pipelining and a single outstanding transfer.
- APB outputs hold their values in all states; only psel/penable drop to 0 outside SETUP/ACCESS.
- busy_i is sampled only in IDLE. A busy_i rise during SETUP/ACCESS does not abort the transfer.
- A held write is presented with cmd_valid_i stable. It is accepted on the first IDLE cycle with busy_i=0.
- pslverr_i is ignored unless pready_i=1 in ACCESS.

Test Plan:
- Write with no wait states: cmd write addr=0x0000_0004 data=0xA55A strb=2'b11, pready_i=1 -> psel 1 at T+1, penable 1 at T+2, paddr=0x4, pwdata=0xA55A, pstrb=2'b11; rsp_valid at T+3, err=0.
- Read with 2 wait states: cmd read addr=0x10, pready_i low for 2 ACCESS cycles then high with prdata=0x1234 -> pstrb=0, pwdata=0; rsp_valid at T+5 with rdata=0x1234, err=0.
- Slave error: write with pslverr_i=1 at pready -> rsp_err_o=1, rsp_rdata_o=0; next command accepted the following cycle.
- Timeout: read with pready_i held 0 -> exactly 16 ACCESS cycles, then psel drops; rsp_valid with err=1, rdata=0.
- Busy gating: busy_i=1 with write pending -> cmd_ready_o=0 and no psel. A read issued meanwhile completes. Drop busy_i -> write accepted the same cycle.
- Reset mid-transfer: rst_ni low during ACCESS -> psel/penable/rsp_valid 0 immediately (async); after release, a new read completes normally.

Source files
------------

// File: rtl/apb_master_module.sv
// APB4 initiator: one command -> one SETUP/ACCESS transfer -> one response pulse.
// Writes are held off while the accelerator reports busy. Each wait-state run is bounded by a timeout.
module apb_master_module #(
  parameter int DATA_WIDTH     = 8,
  parameter int BUS_WIDTH      = 16,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16,
  localparam int MAX_DIM       = BUS_WIDTH / DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_write_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [BUS_WIDTH-1:0]  cmd_wdata_i,
  input  logic [MAX_DIM-1:0]    cmd_strb_i,
  output logic                  rsp_valid_o,
  output logic [BUS_WIDTH-1:0]  rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  psel_o,
  output logic                  penable_o,
  output logic                  pwrite_o,
  output logic [MAX_DIM-1:0]    pstrb_o,
  output logic [BUS_WIDTH-1:0]  pwdata_o,
  output logic [ADDR_WIDTH-1:0] paddr_o,
  input  logic                  pready_i,
  input  logic                  pslverr_i,
  input  logic [BUS_WIDTH-1:0]  prdata_i,
  input  logic                  busy_i
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             timeout;

  // A read is never gated by busy; only writes wait for the accelerator.
  assign cmd_ready_o = (state == IDLE) & ~(cmd_write_i & busy_i);
  assign accept      = cmd_valid_i & cmd_ready_o;
  assign timeout     = (state == ACCESS) & ~pready_i & (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    psel_o      = 1'b0;
    penable_o   = 1'b0;
    rsp_valid_o = 1'b0;
    case (state)
      IDLE:   if (accept) state_nxt = SETUP;
      SETUP: begin
        psel_o    = 1'b1;
        state_nxt = ACCESS;
      end
      ACCESS: begin
        psel_o    = 1'b1;
        penable_o = 1'b1;
        if (pready_i || timeout) state_nxt = RESP;
      end
      RESP: begin
        rsp_valid_o = 1'b1;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Wait-state counter only runs while the slave stalls in ACCESS.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                                        cnt <= '0;
    else if (state == ACCESS && !pready_i && !timeout) cnt <= cnt + CNT_W'(1);
    else                                                cnt <= '0;
  end

  // Read transfers drive zero data and strobes on the bus.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pwrite_o <= 1'b0;
      paddr_o  <= '0;
      pwdata_o <= '0;
      pstrb_o  <= '0;
    end else if (accept) begin
      pwrite_o <= cmd_write_i;
      paddr_o  <= cmd_addr_i;
      pwdata_o <= cmd_write_i ? cmd_wdata_i : '0;
      pstrb_o  <= cmd_write_i ? cmd_strb_i  : '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
    end else if (state == ACCESS) begin
      if (pready_i) begin
        rsp_rdata_o <= pwrite_o ? '0 : prdata_i;
        rsp_err_o   <= pslverr_i;
      end else if (timeout) begin
        rsp_rdata_o <= '0;
        rsp_err_o   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_apb_master_module.sv
// Directed bench for apb_master_module: inputs driven on the falling edge, outputs sampled on the falling edge.
module tb_apb_master_module;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        cmd_valid_i, cmd_ready_o, cmd_write_i;
  logic [31:0] cmd_addr_i;
  logic [15:0] cmd_wdata_i;
  logic [1:0]  cmd_strb_i;
  logic        rsp_valid_o, rsp_err_o;
  logic [15:0] rsp_rdata_o;
  logic        psel_o, penable_o, pwrite_o;
  logic [1:0]  pstrb_o;
  logic [15:0] pwdata_o;
  logic [31:0] paddr_o;
  logic        pready_i, pslverr_i, busy_i;
  logic [15:0] prdata_i;

  int pass_cnt = 0;
  int total_cnt = 0;

  apb_master_module #(.DATA_WIDTH(8), .BUS_WIDTH(16), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
    .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i), .cmd_strb_i(cmd_strb_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o), .pstrb_o(pstrb_o),
    .pwdata_o(pwdata_o), .paddr_o(paddr_o), .pready_i(pready_i), .pslverr_i(pslverr_i),
    .prdata_i(prdata_i), .busy_i(busy_i)
  );

  always #5 clk_i = ~clk_i;

  // Presents a command at the current falling edge; it is accepted on the next rising edge.
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [15:0] wdata, input logic [1:0] strb);
    cmd_valid_i = 1'b1; cmd_write_i = wr; cmd_addr_i = addr; cmd_wdata_i = wdata; cmd_strb_i = strb;
    @(posedge clk_i); #1;
    cmd_valid_i = 1'b0;
  endtask

  task automatic test_reset;
    rst_ni = 1'b0; cmd_valid_i = 1'b0; cmd_write_i = 1'b0; cmd_addr_i = '0; cmd_wdata_i = '0;
    cmd_strb_i = '0; pready_i = 1'b0; pslverr_i = 1'b0; prdata_i = '0; busy_i = 1'b0;
    #12;
    total_cnt++; if ({psel_o, penable_o, rsp_valid_o, rsp_err_o, pwrite_o} !== 5'b0) $display("FAIL rst_ctrl: got %b want 00000", {psel_o, penable_o, rsp_valid_o, rsp_err_o, pwrite_o}); else pass_cnt++;
    total_cnt++; if ({paddr_o, pwdata_o, pstrb_o, rsp_rdata_o} !== 66'd0) $display("FAIL rst_data: got %h want 0", {paddr_o, pwdata_o, pstrb_o, rsp_rdata_o}); else pass_cnt++;
    total_cnt++; if (cmd_ready_o !== 1'b1) $display("FAIL rst_ready_read: got %b want 1", cmd_ready_o); else pass_cnt++;
    cmd_write_i = 1'b1; busy_i = 1'b1; #1;
    total_cnt++; if (cmd_ready_o !== 1'b0) $display("FAIL rst_ready_busy_wr: got %b want 0", cmd_ready_o); else pass_cnt++;
    cmd_write_i = 1'b0; busy_i = 1'b0;
    @(negedge clk_i); rst_ni = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic test_write_nowait;
    pready_i = 1'b1;
    total_cnt++; if (cmd_ready_o !== 1'b1) $display("FAIL wr_ready: got %b want 1", cmd_ready_o); else pass_cnt++;
    issue(1'b1, 32'h0000_0004, 16'hA55A, 2'b11);
    @(negedge clk_i);
    total_cnt++; if ({psel_o, penable_o, pwrite_o} !== 3'b101) $display("FAIL wr_setup_ctrl: got %b want 101", {psel_o, penable_o, pwrite_o}); else pass_cnt++;
    total_cnt++; if ({paddr_o, pwdata_o, pstrb_o} !== {32'h4, 16'hA55A, 2'b11}) $display("FAIL wr_setup_bus: got %h/%h/%b want 4/a55a/11", paddr_o, pwdata_o, pstrb_o); else pass_cnt++;
    total_cnt++; if (cmd_ready_o !== 1'b0) $display("FAIL wr_busy_ready: got %b want 0", cmd_ready_o); else pass_cnt++;
    @(negedge clk_i);
    total_cnt++; if ({psel_o, penable_o, rsp_valid_o} !== 3'b110) $display("FAIL wr_access: got %b want 110", {psel_o, penable_o, rsp_valid_o}); else pass_cnt++;
    @(negedge clk_i);
    total_cnt++; if ({psel_o, penable_o, rsp_valid_o, rsp_err_o} !== 4'b0010) $display("FAIL wr_resp: got %b want 0010", {psel_o, penable_o, rsp_valid_o, rsp_err_o}); else pass_cnt++;
    total_cnt++; if (rsp_rdata_o !== 16'h0) $display("FAIL wr_resp_rdata: got %h want 0000", rsp_rdata_o); else pass_cnt++;
    @(negedge clk_i);
    total_cnt++; if (rsp_valid_o !== 1'b0) $display("FAIL wr_idle_rsp: got %b want 0", rsp_valid_o); else pass_cnt++;
    total_cnt++; if ({paddr_o, pwdata_o} !== {32'h4, 16'hA55A}) $display("FAIL wr_idle_hold: got %h/%h want 4/a55a", paddr_o, pwdata_o); else pass_cnt++;
  endtask

  task automatic test_read_wait;
    pready_i = 1'b0; pslverr_i = 1'b1;
    issue(1'b0, 32'h10, 16'hFFFF, 2'b11);
    @(negedge clk_i);
    total_cnt++; if ({psel_o, pwrite_o, pwdata_o, pstrb_o} !== {1'b1, 1'b0, 16'h0, 2'b00}) $display("FAIL rd_setup: got psel=%b pwrite=%b pwdata=%h pstrb=%b want 1/0/0000/00", psel_o, pwrite_o, pwdata_o, pstrb_o); else pass_cnt++;
    total_cnt++; if (paddr_o !== 32'h10) $display("FAIL rd_addr: got %h want 00000010", paddr_o); else pass_cnt++;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i);
      total_cnt++; if ({penable_o, rsp_valid_o} !== 2'b10) $display("FAIL rd_wait%0d: got %b want 10", i, {penable_o, rsp_valid_o}); else pass_cnt++;
    end
    @(negedge clk_i);
    pready_i = 1'b1; pslverr_i = 1'b0; prdata_i = 16'h1234;
    @(negedge clk_i);
    total_cnt++; if ({rsp_valid_o, rsp_err_o, rsp_rdata_o} !== {2'b10, 16'h1234}) $display("FAIL rd_resp: got v=%b e=%b d=%h want 1/0/1234", rsp_valid_o, rsp_err_o, rsp_rdata_o); else pass_cnt++;
    @(negedge clk_i);
    total_cnt++; if ({rsp_valid_o, rsp_rdata_o} !== {1'b0, 16'h1234}) $display("FAIL rd_hold: got v=%b d=%h want 0/1234", rsp_valid_o, rsp_rdata_o); else pass_cnt++;
  endtask

  task automatic test_slverr;
    pready_i = 1'b1; pslverr_i = 1'b1; prdata_i = 16'hDEAD;
    issue(1'b1, 32'h8, 16'h1111, 2'b01);
    @(negedge clk_i); @(negedge clk_i); @(negedge clk_i);
    total_cnt++; if ({rsp_valid_o, rsp_err_o, rsp_rdata_o} !== {2'b11, 16'h0}) $display("FAIL err_resp: got v=%b e=%b d=%h want 1/1/0000", rsp_valid_o, rsp_err_o, rsp_rdata_o); else pass_cnt++;
    pslverr_i = 1'b0; prdata_i = 16'h5678;
    @(negedge clk_i);
    issue(1'b0, 32'h20, 16'h0, 2'b00);
    @(negedge clk_i);
    total_cnt++; if ({psel_o, penable_o, paddr_o} !== {2'b10, 32'h20}) $display("FAIL err_next_setup: got %b/%h want 10/00000020", {psel_o, penable_o}, paddr_o); else pass_cnt++;
    @(negedge clk_i); @(negedge clk_i);
    total_cnt++; if ({rsp_valid_o, rsp_err_o, rsp_rdata_o} !== {2'b10, 16'h5678}) $display("FAIL err_next_resp: got v=%b e=%b d=%h want 1/0/5678", rsp_valid_o, rsp_err_o, rsp_rdata_o); else pass_cnt++;
    @(negedge clk_i);
  endtask

  task automatic test_timeout;
    int acc = 0;
    pready_i = 1'b0;
    issue(1'b0, 32'h30, 16'h0, 2'b00);
    @(negedge clk_i);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      if (psel_o && penable_o) acc++;
      else break;
    end
    total_cnt++; if (acc !== 16) $display("FAIL to_access_cycles: got %0d want 16", acc); else pass_cnt++;
    total_cnt++; if ({psel_o, rsp_valid_o, rsp_err_o, rsp_rdata_o} !== {3'b011, 16'h0}) $display("FAIL to_resp: got psel=%b v=%b e=%b d=%h want 0/1/1/0000", psel_o, rsp_valid_o, rsp_err_o, rsp_rdata_o); else pass_cnt++;
    @(negedge clk_i);
  endtask

  task automatic test_busy;
    busy_i = 1'b1;
    cmd_valid_i = 1'b1; cmd_write_i = 1'b1; cmd_addr_i = 32'h40; cmd_wdata_i = 16'hBEEF; cmd_strb_i = 2'b11;
    #1;
    total_cnt++; if (cmd_ready_o !== 1'b0) $display("FAIL busy_ready: got %b want 0", cmd_ready_o); else pass_cnt++;
    @(negedge clk_i);
    total_cnt++; if ({psel_o, cmd_ready_o} !== 2'b00) $display("FAIL busy_held: got %b want 00", {psel_o, cmd_ready_o}); else pass_cnt++;
    cmd_write_i = 1'b0; cmd_addr_i = 32'h50; pready_i = 1'b1; prdata_i = 16'h0A0A; #1;
    total_cnt++; if (cmd_ready_o !== 1'b1) $display("FAIL busy_read_ready: got %b want 1", cmd_ready_o); else pass_cnt++;
    issue(1'b0, 32'h50, 16'h0, 2'b00);
    @(negedge clk_i);
    total_cnt++; if ({psel_o, pwrite_o, paddr_o} !== {2'b10, 32'h50}) $display("FAIL busy_read_setup: got %b/%h want 10/00000050", {psel_o, pwrite_o}, paddr_o); else pass_cnt++;
    @(negedge clk_i); @(negedge clk_i);
    total_cnt++; if ({rsp_valid_o, rsp_err_o, rsp_rdata_o} !== {2'b10, 16'h0A0A}) $display("FAIL busy_read_resp: got v=%b e=%b d=%h want 1/0/0a0a", rsp_valid_o, rsp_err_o, rsp_rdata_o); else pass_cnt++;
    @(negedge clk_i);
    cmd_valid_i = 1'b1; cmd_write_i = 1'b1; cmd_addr_i = 32'h40; cmd_wdata_i = 16'hBEEF; cmd_strb_i = 2'b11;
    @(negedge clk_i);
    total_cnt++; if (psel_o !== 1'b0) $display("FAIL busy_wr_still_held: got %b want 0", psel_o); else pass_cnt++;
    busy_i = 1'b0; #1;
    total_cnt++; if (cmd_ready_o !== 1'b1) $display("FAIL busy_drop_ready: got %b want 1", cmd_ready_o); else pass_cnt++;
    @(posedge clk_i); #1; cmd_valid_i = 1'b0;
    @(negedge clk_i);
    total_cnt++; if ({psel_o, pwrite_o, paddr_o, pwdata_o} !== {2'b11, 32'h40, 16'hBEEF}) $display("FAIL busy_wr_setup: got %b/%h/%h want 11/00000040/beef", {psel_o, pwrite_o}, paddr_o, pwdata_o); else pass_cnt++;
    busy_i = 1'b1;
    @(negedge clk_i);
    total_cnt++; if ({psel_o, penable_o} !== 2'b11) $display("FAIL busy_rise_access: got %b want 11", {psel_o, penable_o}); else pass_cnt++;
    @(negedge clk_i);
    total_cnt++; if ({rsp_valid_o, rsp_err_o} !== 2'b10) $display("FAIL busy_wr_resp: got %b want 10", {rsp_valid_o, rsp_err_o}); else pass_cnt++;
    busy_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic test_reset_mid;
    pready_i = 1'b0;
    issue(1'b0, 32'h60, 16'h0, 2'b00);
    @(negedge clk_i); @(negedge clk_i);
    total_cnt++; if ({psel_o, penable_o} !== 2'b11) $display("FAIL rstmid_access: got %b want 11", {psel_o, penable_o}); else pass_cnt++;
    #2 rst_ni = 1'b0; #1;
    total_cnt++; if ({psel_o, penable_o, rsp_valid_o} !== 3'b000) $display("FAIL rstmid_async: got %b want 000", {psel_o, penable_o, rsp_valid_o}); else pass_cnt++;
    total_cnt++; if (paddr_o !== 32'h0) $display("FAIL rstmid_paddr: got %h want 0", paddr_o); else pass_cnt++;
    @(negedge clk_i); rst_ni = 1'b1;
    @(negedge clk_i);
    total_cnt++; if (rsp_valid_o !== 1'b0) $display("FAIL rstmid_no_rsp: got %b want 0", rsp_valid_o); else pass_cnt++;
    pready_i = 1'b1; prdata_i = 16'h7777;
    issue(1'b0, 32'h70, 16'h0, 2'b00);
    @(negedge clk_i); @(negedge clk_i); @(negedge clk_i);
    total_cnt++; if ({rsp_valid_o, rsp_err_o, rsp_rdata_o} !== {2'b10, 16'h7777}) $display("FAIL rstmid_after: got v=%b e=%b d=%h want 1/0/7777", rsp_valid_o, rsp_err_o, rsp_rdata_o); else pass_cnt++;
    @(negedge clk_i);
  endtask

  initial begin
    test_reset();
    test_write_nowait();
    test_read_wait();
    test_slverr();
    test_timeout();
    test_busy();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
